axis_threshold_calibrator: RTL and testbench

Configuration controller for the quadrature position tracker. On a start pulse it holds the tracker in reset and observes signal_a (low half of the shared AXI-Stream sample bus) over a programmable window of accepted beats. From the signed min/max it derives and applies lower_threshold and upper_threshold, then releases the tracker. It sits beside the tracker on the same sample tap, between the register bank and the tracker's threshold and reset inputs.

---
 rtl/position_tracker_pkg.sv | 27 ++
 rtl/axis_threshold_calibrator_if.sv | 11 +
 rtl/axis_minmax_window.sv | 57 +++++
 rtl/axis_threshold_calibrator.sv | 164 ++++++++++++++++
 tb/tb_axis_threshold_calibrator.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/position_tracker_pkg.sv
// Shared types and saturation helpers for the quadrature position tracker and its threshold calibrator.
package position_tracker_pkg;

    localparam int unsigned HALF_W = 16;

    localparam logic signed [HALF_W-1:0] SAT_MAX = {1'b0, {(HALF_W-1){1'b1}}};
    localparam logic signed [HALF_W-1:0] SAT_MIN = {1'b1, {(HALF_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_APPLY   = 2'd3
    } cal_state_t;

    // Clamp a two-bit-wider signed value into the HALF_W signed range.
    function automatic logic signed [HALF_W-1:0] sat_w2(input logic signed [HALF_W+1:0] x);
        logic signed [HALF_W+1:0] hi;
        logic signed [HALF_W+1:0] lo;
        hi = {2'b00, SAT_MAX};
        lo = {2'b11, SAT_MIN};
        if (x > hi) return SAT_MAX;
        if (x < lo) return SAT_MIN;
        return x[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/axis_threshold_calibrator_if.sv
// AXI-Stream sample tap shared by the calibrator and the tracker.
interface axis_threshold_calibrator_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/axis_minmax_window.sv
// Signed running min/max over a window of accepted beats, flagging the final beat.
module axis_minmax_window
    import position_tracker_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = HALF_W,
    parameter int unsigned CNT_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       beat_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic [CNT_WIDTH-1:0]       length_i,
    output logic signed [SAMPLE_W-1:0] min_o,
    output logic signed [SAMPLE_W-1:0] max_o,
    output logic                       last_c
);

    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [SAMPLE_W-1:0] min_q, min_d;
    logic signed [SAMPLE_W-1:0] max_q, max_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;

    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (clear_i) begin
            min_d   = S_MAX;
            max_d   = S_MIN;
            count_d = '0;
        end else if (beat_i) begin
            if (sample_i < min_q) min_d = sample_i;
            if (sample_i > max_q) max_d = sample_i;
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q   <= S_MAX;
            max_q   <= S_MIN;
            count_q <= '0;
        end else begin
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign last_c = beat_i && (count_q == (length_i - CNT_WIDTH'(1)));
    assign min_o  = min_q;
    assign max_o  = max_q;

endmodule

// File: rtl/axis_threshold_calibrator.sv
// Holds the tracker in reset while measuring signal_a, then programs its hysteresis thresholds.
module axis_threshold_calibrator
    import position_tracker_pkg::*;
#(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 2 * HALF_W,
    parameter int unsigned CNT_WIDTH          = 24
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     window_length,
    input  logic [3:0]               hysteresis_shift,
    axis_threshold_calibrator_if.slave s_axis,
    output logic signed [HALF_W-1:0] lower_threshold,
    output logic signed [HALF_W-1:0] upper_threshold,
    output logic                     thresholds_valid,
    output logic                     cal_error,
    output logic                     busy,
    output logic                     tracker_aresetn
);

    cal_state_t state_q, state_d;

    logic [CNT_WIDTH-1:0]     window_q, window_d;
    logic [3:0]               shift_q, shift_d;
    logic signed [HALF_W:0]   center_q, center_d;
    logic [HALF_W:0]          delta_q, delta_d;
    logic                     flat_q, flat_d;
    logic signed [HALF_W-1:0] lower_q, lower_d;
    logic signed [HALF_W-1:0] upper_q, upper_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     trk_q, trk_d;

    logic                     clear_c, beat_c, last_c;
    logic signed [HALF_W-1:0] signal_a, win_min, win_max;
    logic signed [HALF_W:0]   sum_c, center_c;
    logic [HALF_W:0]          span_c, delta_c;
    logic signed [HALF_W+1:0] lower_x, upper_x;
    logic                     unused_signal_b;

    // Passive tap: ready whenever out of reset, signal_b is not needed here.
    assign s_axis.tready   = aresetn;
    assign signal_a        = s_axis.tdata[HALF_W-1:0];
    assign unused_signal_b = ^s_axis.tdata[S_AXIS_TDATA_WIDTH-1:HALF_W];
    assign beat_c          = (state_q == ST_MEASURE) && s_axis.tvalid && aresetn;

    axis_minmax_window #(
        .SAMPLE_W  (HALF_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_window (
        .clk      (aclk),
        .rst_n    (aresetn),
        .clear_i  (clear_c),
        .beat_i   (beat_c),
        .sample_i (signal_a),
        .length_i (window_q),
        .min_o    (win_min),
        .max_o    (win_max),
        .last_c   (last_c)
    );

    // Widened arithmetic so neither the sum nor the span can overflow.
    assign sum_c    = {win_max[HALF_W-1], win_max} + {win_min[HALF_W-1], win_min};
    assign center_c = sum_c >>> 1;
    assign span_c   = {win_max[HALF_W-1], win_max} - {win_min[HALF_W-1], win_min};
    assign delta_c  = span_c >> shift_q;
    assign lower_x  = {center_q[HALF_W], center_q} - {1'b0, delta_q};
    assign upper_x  = {center_q[HALF_W], center_q} + {1'b0, delta_q};

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        shift_d  = shift_q;
        center_d = center_q;
        delta_d  = delta_q;
        flat_d   = flat_q;
        lower_d  = lower_q;
        upper_d  = upper_q;
        valid_d  = valid_q;
        err_d    = err_q;
        busy_d   = busy_q;
        trk_d    = trk_q;
        clear_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MEASURE;
                    window_d = (window_length == '0) ? CNT_WIDTH'(1) : window_length;
                    shift_d  = hysteresis_shift;
                    clear_c  = 1'b1;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    trk_d    = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (last_c) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                center_d = center_c;
                delta_d  = delta_c;
                flat_d   = (span_c == '0);
                state_d  = ST_APPLY;
            end
            ST_APPLY: begin
                if (flat_q) begin
                    err_d = 1'b1;
                    trk_d = valid_q;
                end else begin
                    lower_d = sat_w2(lower_x);
                    upper_d = sat_w2(upper_x);
                    valid_d = 1'b1;
                    trk_d   = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            window_q <= CNT_WIDTH'(1);
            shift_q  <= '0;
            center_q <= '0;
            delta_q  <= '0;
            flat_q   <= 1'b0;
            lower_q  <= '0;
            upper_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            trk_q    <= 1'b0;
        end else begin
            window_q <= window_d;
            shift_q  <= shift_d;
            center_q <= center_d;
            delta_q  <= delta_d;
            flat_q   <= flat_d;
            lower_q  <= lower_d;
            upper_q  <= upper_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            trk_q    <= trk_d;
        end
    end

    assign lower_threshold  = lower_q;
    assign upper_threshold  = upper_q;
    assign thresholds_valid = valid_q;
    assign cal_error        = err_q;
    assign busy             = busy_q;
    assign tracker_aresetn  = trk_q;

endmodule

// File: tb/tb_axis_threshold_calibrator.sv
// Randomized self-checking bench for axis_threshold_calibrator against a window min/max reference model.
module tb_axis_threshold_calibrator;

    localparam int unsigned W  = 32;
    localparam int unsigned HW = 16;
    localparam int unsigned CW = 24;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 start = 1'b0;
    logic [CW-1:0]        window_length = '0;
    logic [3:0]           hysteresis_shift = '0;
    logic signed [HW-1:0] lower_threshold, upper_threshold;
    logic                 thresholds_valid, cal_error, busy, tracker_aresetn;

    axis_threshold_calibrator_if #(.DATA_W(W)) s_axis ();

    axis_threshold_calibrator #(
        .S_AXIS_TDATA_WIDTH (W),
        .CNT_WIDTH          (CW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .start            (start),
        .window_length    (window_length),
        .hysteresis_shift (hysteresis_shift),
        .s_axis           (s_axis),
        .lower_threshold  (lower_threshold),
        .upper_threshold  (upper_threshold),
        .thresholds_valid (thresholds_valid),
        .cal_error        (cal_error),
        .busy             (busy),
        .tracker_aresetn  (tracker_aresetn)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the tracker should currently be programmed with.
    int m_lower = 0;
    int m_upper = 0;
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_half(input int s);
        if (s < 0 && (s % 2) != 0) return s / 2 - 1;
        return s / 2;
    endfunction

    // Apply one calibration's worth of samples to the model.
    function automatic void model_cal(input int smp[$], input int sh);
        int mn, mx, c, d;
        mn = smp[0];
        mx = smp[0];
        foreach (smp[i]) begin
            if (smp[i] < mn) mn = smp[i];
            if (smp[i] > mx) mx = smp[i];
        end
        if (mx == mn) begin
            m_err = 1'b1;
        end else begin
            c = floor_half(mx + mn);
            d = (mx - mn) / (1 << sh);
            m_lower = clamp16(c - d);
            m_upper = clamp16(c + d);
            m_valid = 1'b1;
            m_err   = 1'b0;
        end
    endfunction

    function automatic logic [35:0] obs();
        return {lower_threshold, upper_threshold, thresholds_valid, cal_error, busy, tracker_aresetn};
    endfunction

    function automatic logic [35:0] exp_vec(input bit in_cal);
        logic [15:0] lo, up;
        lo = 16'(m_lower);
        up = 16'(m_upper);
        return {lo, up, m_valid, m_err, in_cal, in_cal ? 1'b0 : m_valid};
    endfunction

    function automatic void drive_idle_bus();
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = $urandom();
    endfunction

    // Start a calibration and feed its beats; returns one cycle after the final beat edge.
    task automatic run_cal(input int win, input int sh, input int smp[$], input int gaps[$], input bit poke_start);
        start            = 1'b1;
        window_length    = CW'(win);
        hysteresis_shift = 4'(sh);
        s_axis.tvalid    = 1'b1;
        s_axis.tdata     = $urandom();
        step();
        start   = 1'b0;
        m_err   = 1'b0;
        foreach (smp[i]) begin
            if (i < gaps.size()) begin
                repeat (gaps[i]) begin
                    drive_idle_bus();
                    step();
                end
            end
            start         = poke_start && (i == 1);
            window_length = CW'($urandom_range(1, 2));
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = {16'($urandom()), 16'(smp[i])};
            step();
            start = 1'b0;
        end
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = $urandom();
    endtask

    task automatic test_reset();
        drive_idle_bus();
        #2;
        checks++;
        if (obs() !== 36'd0 || s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h tready %b, expected 0 tready 0", obs(), s_axis.tready);
        end
        step();
        aresetn = 1'b1;
        step();
        checks++;
        if (obs() !== 36'd0 || s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got %h tready %b, expected 0 tready 1", obs(), s_axis.tready);
        end
    endtask

    task automatic test_basic();
        int smp[$] = '{100, -300, 500, 0};
        int none[$];
        run_cal(4, 2, smp, none, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) model_cal(smp, 2);
            checks++;
            if (obs() !== exp_vec(k < 2)) begin
                errors++;
                $display("FAIL basic_cyc%0d: got %h expected %h", k + 1, obs(), exp_vec(k < 2));
            end
            if (k < 2) step();
        end
        checks++;
        if (lower_threshold !== -16'sd100 || upper_threshold !== 16'sd300) begin
            errors++;
            $display("FAIL basic_values: got %0d/%0d expected -100/300", lower_threshold, upper_threshold);
        end
    endtask

    task automatic test_saturation();
        int smp[$] = '{-32768, 32767};
        int none[$];
        run_cal(2, 0, smp, none, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) model_cal(smp, 0);
            checks++;
            if (obs() !== exp_vec(k < 2)) begin
                errors++;
                $display("FAIL sat_cyc%0d: got %h expected %h", k + 1, obs(), exp_vec(k < 2));
            end
            if (k < 2) step();
        end
        checks++;
        if (lower_threshold !== -16'sd32768 || upper_threshold !== 16'sd32767) begin
            errors++;
            $display("FAIL sat_values: got %0d/%0d expected -32768/32767", lower_threshold, upper_threshold);
        end
    endtask

    task automatic test_flat();
        int smp[$] = '{42, 42, 42};
        int none[$];
        int sh;
        sh = $urandom_range(0, 15);
        run_cal(3, sh, smp, none, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) model_cal(smp, sh);
            checks++;
            if (obs() !== exp_vec(k < 2)) begin
                errors++;
                $display("FAIL flat_cyc%0d: got %h expected %h", k + 1, obs(), exp_vec(k < 2));
            end
            if (k < 2) step();
        end
        checks++;
        if (cal_error !== 1'b1 || tracker_aresetn !== thresholds_valid) begin
            errors++;
            $display("FAIL flat_flags: got err %b trk %b expected err 1 trk %b", cal_error, tracker_aresetn, m_valid);
        end
    endtask

    task automatic test_gaps();
        int smp[$];
        int none[$];
        int gaps[$] = '{0, 2, 1};
        logic [31:0] ref_thr;
        for (int i = 0; i < 3; i++) smp.push_back($urandom_range(0, 4000) - 2000);
        smp[0] = -2500;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) run_cal(3, 1, smp, none, 1'b0);
            else           run_cal(3, 1, smp, gaps, 1'b0);
            step();
            step();
            model_cal(smp, 1);
            checks++;
            if (obs() !== exp_vec(1'b0)) begin
                errors++;
                $display("FAIL gaps_pass%0d: got %h expected %h", pass, obs(), exp_vec(1'b0));
            end
            if (pass == 0) ref_thr = {lower_threshold, upper_threshold};
        end
        checks++;
        if ({lower_threshold, upper_threshold} !== ref_thr) begin
            errors++;
            $display("FAIL gaps_vs_gapless: got %h expected %h", {lower_threshold, upper_threshold}, ref_thr);
        end
    endtask

    task automatic test_restart_and_zero();
        int smp[$] = '{-700, 900, 50};
        int one[$] = '{1234};
        int none[$];
        run_cal(3, 3, smp, none, 1'b1);
        step();
        step();
        model_cal(smp, 3);
        checks++;
        if (obs() !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL restart_ignored: got %h expected %h", obs(), exp_vec(1'b0));
        end
        run_cal(0, 0, one, none, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) model_cal(one, 0);
            checks++;
            if (obs() !== exp_vec(k < 2)) begin
                errors++;
                $display("FAIL window0_cyc%0d: got %h expected %h", k + 1, obs(), exp_vec(k < 2));
            end
            if (k < 2) step();
        end
    endtask

    task automatic test_back_to_back();
        int a[$] = '{-10, 30};
        int b[$] = '{5000, -5000, 0, 7};
        int none[$];
        run_cal(2, 1, a, none, 1'b0);
        step();
        step();
        model_cal(a, 1);
        checks++;
        if (obs() !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", obs(), exp_vec(1'b0));
        end
        run_cal(4, 4, b, none, 1'b0);
        step();
        step();
        model_cal(b, 4);
        checks++;
        if (obs() !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", obs(), exp_vec(1'b0));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int smp[$];
            int gaps[$];
            int win, sh, base, spread;
            win    = $urandom_range(1, 6);
            sh     = $urandom_range(0, 15);
            base   = $urandom_range(0, 65535) - 32768;
            spread = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 65535);
            for (int i = 0; i < win; i++) begin
                int v;
                v = base + $urandom_range(0, spread) - spread / 2;
                smp.push_back(clamp16(v));
                gaps.push_back($urandom_range(0, 2));
            end
            run_cal(win, sh, smp, gaps, $urandom_range(0, 1) == 1);
            for (int k = 0; k < 3; k++) begin
                if (k == 2) model_cal(smp, sh);
                checks++;
                if (obs() !== exp_vec(k < 2)) begin
                    errors++;
                    $display("FAIL rand%0d_cyc%0d: got %h expected %h", it, k + 1, obs(), exp_vec(k < 2));
                end
                if (k < 2) step();
            end
        end
    endtask

    task automatic test_reset_mid();
        int part[$] = '{300, -300};
        int full[$] = '{-40, 80, 10};
        int none[$];
        run_cal(5, 0, part, none, 1'b0);
        aresetn = 1'b0;
        #2;
        checks++;
        if (obs() !== 36'd0 || s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h tready %b expected 0 tready 0", obs(), s_axis.tready);
        end
        m_lower = 0;
        m_upper = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        step();
        aresetn = 1'b1;
        drive_idle_bus();
        step();
        checks++;
        if (obs() !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL reset_mid_idle: got %h expected %h", obs(), exp_vec(1'b0));
        end
        run_cal(3, 2, full, none, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) model_cal(full, 2);
            checks++;
            if (obs() !== exp_vec(k < 2)) begin
                errors++;
                $display("FAIL reset_mid_recal_cyc%0d: got %h expected %h", k + 1, obs(), exp_vec(k < 2));
            end
            if (k < 2) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_flat();
        test_gaps();
        test_restart_and_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        drive_idle_bus();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
